// File: rtl/axis_wr_arb.sv
// Packet-granular round-robin arbiter merging N AXI-Stream requesters onto one write port.
// Latency: 0 cycles in bypass, 1 cycle with AXIS_WR_ARB_OUT_REG_EN (2-entry skid buffer).
// Backpressure: grant is held until tlast is accepted; s_tready follows m_tready (bypass) or buffer space (registered).
module axis_wr_arb #(
    parameter int N  = 4,
    parameter int DW = 8,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tlast,
    output logic [IW-1:0]   m_tid,
    output logic            busy_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] g, g_nxt;
    logic [IW-1:0] hi_pick, lo_pick;
    logic          hi_vld, lo_vld;
    logic          sel_vld, sel_last;
    logic [DW-1:0] sel_data;
    logic          slot_rdy;
    logic          acc;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_pick = '0;
        hi_vld  = 1'b0;
        lo_pick = '0;
        lo_vld  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (s_tvalid[i] && (IW'(i) >= ptr)) begin
                hi_pick = IW'(i);
                hi_vld  = 1'b1;
            end
            if (s_tvalid[i]) begin
                lo_pick = IW'(i);
                lo_vld  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        s_tready = '0;
        for (int i = 0; i < N; i++) begin
            if (g == IW'(i)) begin
                sel_vld     = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_data    = s_tdata[i*DW +: DW];
                s_tready[i] = slot_rdy;
            end
        end
    end

    assign busy_o = (state == BUSY);
    assign acc    = slot_rdy && sel_vld;

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (hi_vld || lo_vld) begin
                    g_nxt     = hi_vld ? hi_pick : lo_pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (acc && sel_last) begin
                    ptr_nxt   = (g == IW'(N - 1)) ? '0 : g + IW'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            g     <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            g     <= g_nxt;
        end
    end

`ifdef AXIS_WR_ARB_OUT_REG_EN
    typedef struct packed {
        logic          last;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } beat_t;

    beat_t      buf_q [2];
    logic       wr_idx, rd_idx;
    logic [1:0] cnt;
    logic       pop;

    // Ready depends only on registered occupancy, so m_tready never reaches s_tready.
    assign slot_rdy = busy_o && !cnt[1];
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (acc) begin
                buf_q[wr_idx] <= {sel_last, g, sel_data};
                wr_idx        <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            cnt <= cnt + {1'b0, acc} - {1'b0, pop};
        end
    end

    assign m_tvalid = (cnt != 2'd0);
    assign m_tdata  = buf_q[rd_idx].data;
    assign m_tlast  = buf_q[rd_idx].last;
    assign m_tid    = buf_q[rd_idx].id;
`else
    assign slot_rdy = busy_o && m_tready;
    assign m_tvalid = busy_o && sel_vld;
    assign m_tdata  = busy_o ? sel_data : '0;
    assign m_tlast  = busy_o && sel_last;
    assign m_tid    = busy_o ? g : '0;
`endif

endmodule
